mul_result_stage: RTL and testbench

Pipelined result stage directly downstream of the execute-stage multiplier. It takes the unsigned 64-bit magnitude product plus operand sign information and applies the two's-complement sign correction. It then selects the RISC-V M-extension result half (MUL/MULH/MULHSU/MULHU) and presents a 32-bit write-back value to the write-back stage over a valid/ready handshake, with flush support.

---
 rtl/mul_result_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mul_result_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_stage.sv
// -----------------------------------------------------------------------------
// mul_result_stage
//
// Result stage that sits right after the execute-stage multiplier. The
// multiplier hands over the unsigned magnitude product |a|*|b| together with
// the operand sign information. This stage then:
//   1. applies the two's-complement sign correction, and
//   2. selects the low or high half of the product for the RISC-V M-extension
//      op (MUL / MULH / MULHSU / MULHU).
// The 32-bit write-back value goes to the write-back stage over a valid/ready
// handshake.
//
// Build option:
//   MUL_RESULT_INREG_EN  defined   -> input register slice S1 plus output
//                                     register slice S2 (latency 2). The
//                                     negation adder is driven from S1, so it
//                                     stays off the multiplier's timing path.
//                        undefined -> S2 only (latency 1). The sign
//                                     correction is computed combinationally
//                                     from the inputs.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mul_valid_i/ready_o   input handshake from the multiplier
//   mul_res_w             unsigned 2*XLEN magnitude product
//   id_a_signed_r/_b_     operand treated as signed
//   id_ra_sign_r/_rb_     sign bit (bit XLEN-1) of the original operand
//   mul_op_i              00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   mul_rd_i              destination register
//   flush_i               drop every in-flight entry at the next edge
//   wb_valid_o/ready_i    output handshake to write-back
//   wb_rd_o, wb_result_o  destination register and result being presented
//   busy_o                any pipeline entry valid
// -----------------------------------------------------------------------------
module mul_result_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mul_valid_i,
  output logic              mul_ready_o,
  input  logic [2*XLEN-1:0] mul_res_w,
  input  logic              id_a_signed_r,
  input  logic              id_b_signed_r,
  input  logic              id_ra_sign_r,
  input  logic              id_rb_sign_r,
  input  logic [1:0]        mul_op_i,
  input  logic [RD_W-1:0]   mul_rd_i,
  input  logic              flush_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [RD_W-1:0]   wb_rd_o,
  output logic [XLEN-1:0]   wb_result_o,
  output logic              busy_o
);

  localparam int PW = 2 * XLEN;

  // Op encoding: only MUL takes the low half.
  localparam logic [1:0] OP_MUL = 2'b00;

  logic accept;
  logic negate_w;

  // Output slice (S2) state.
  logic              s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]   s2_result_q, s2_result_d;
  logic [RD_W-1:0]   s2_rd_q, s2_rd_d;
  logic              s2_adv;
  logic              s2_load;

  // The source that feeds the correction/select logic in front of S2.
  logic [PW-1:0]     src_prod;
  logic              src_neg;
  logic [1:0]        src_op;
  logic [RD_W-1:0]   src_rd;

  logic [PW-1:0]     corrected;
  logic [XLEN-1:0]   selected;

  // The result is negative when exactly one operand is signed AND negative.
  assign negate_w = (id_a_signed_r & id_ra_sign_r) ^ (id_b_signed_r & id_rb_sign_r);
  assign accept   = mul_valid_i & mul_ready_o;

  // S2 can take new data when it is empty or its entry leaves this cycle.
  assign s2_adv   = wb_ready_i | ~s2_valid_q;

`ifdef MUL_RESULT_INREG_EN
  // ---------------------------------------------------------------------------
  // Input slice S1: it captures the raw product so that the 64-bit negation
  // starts from a register.
  // ---------------------------------------------------------------------------
  logic              s1_valid_q, s1_valid_d;
  logic [PW-1:0]     s1_prod_q, s1_prod_d;
  logic              s1_neg_q, s1_neg_d;
  logic [1:0]        s1_op_q, s1_op_d;
  logic [RD_W-1:0]   s1_rd_q, s1_rd_d;
  logic              s1_adv;

  assign s1_adv      = s1_valid_q & s2_adv;
  // This is combinational from wb_ready_i. A full pipe frees up in the same
  // cycle that write-back starts consuming.
  assign mul_ready_o = ~s1_valid_q | s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_neg_d   = s1_neg_q;
    s1_op_d    = s1_op_q;
    s1_rd_d    = s1_rd_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (accept) begin
      s1_prod_d = mul_res_w;
      s1_neg_d  = negate_w;
      s1_op_d   = mul_op_i;
      s1_rd_d   = mul_rd_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_neg_q   <= 1'b0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_neg_q   <= s1_neg_d;
      s1_op_q    <= s1_op_d;
      s1_rd_q    <= s1_rd_d;
    end
  end

  assign src_prod = s1_prod_q;
  assign src_neg  = s1_neg_q;
  assign src_op   = s1_op_q;
  assign src_rd   = s1_rd_q;
  assign s2_load  = s1_adv;
  assign busy_o   = s1_valid_q | s2_valid_q;
`else
  // ---------------------------------------------------------------------------
  // Single-stage build: the inputs feed S2 directly.
  // ---------------------------------------------------------------------------
  assign mul_ready_o = ~s2_valid_q | wb_ready_i;
  assign src_prod    = mul_res_w;
  assign src_neg     = negate_w;
  assign src_op      = mul_op_i;
  assign src_rd      = mul_rd_i;
  assign s2_load     = accept;
  assign busy_o      = s2_valid_q;
`endif

  // Two's-complement negation wraps mod 2^PW. A zero product stays zero.
  assign corrected = src_neg ? (~src_prod + {{(PW-1){1'b0}}, 1'b1}) : src_prod;
  assign selected  = (src_op == OP_MUL) ? corrected[XLEN-1:0] : corrected[PW-1:XLEN];

  // ---------------------------------------------------------------------------
  // Output slice S2. Its data only loads together with s2_load. A stalled
  // result (valid, not ready) therefore holds steady.
  // ---------------------------------------------------------------------------
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_rd_d     = s2_rd_q;
    if (flush_i) begin
      s2_valid_d = 1'b0;
    end else if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (wb_ready_i) begin
      s2_valid_d = 1'b0;
    end
    if (s2_load) begin
      s2_result_d = selected;
      s2_rd_d     = src_rd;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_rd_q     <= '0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_rd_q     <= s2_rd_d;
    end
  end

  assign wb_valid_o  = s2_valid_q;
  assign wb_result_o = s2_result_q;
  assign wb_rd_o     = s2_rd_q;

endmodule

// File: tb/tb_mul_result_stage.sv
module tb_mul_result_stage;

`ifdef MUL_RESULT_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = LAT;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mul_valid_i = 1'b0;
  logic        mul_ready_o;
  logic [63:0] mul_res_w = '0;
  logic        id_a_signed_r = 1'b0, id_b_signed_r = 1'b0;
  logic        id_ra_sign_r = 1'b0, id_rb_sign_r = 1'b0;
  logic [1:0]  mul_op_i = '0;
  logic [4:0]  mul_rd_i = '0;
  logic        flush_i = 1'b0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b1;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_result_o;
  logic        busy_o;

  mul_result_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o),
    .mul_res_w(mul_res_w),
    .id_a_signed_r(id_a_signed_r), .id_b_signed_r(id_b_signed_r),
    .id_ra_sign_r(id_ra_sign_r), .id_rb_sign_r(id_rb_sign_r),
    .mul_op_i(mul_op_i), .mul_rd_i(mul_rd_i), .flush_i(flush_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] prod;
    logic        as, bs, ras, rbs;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;

  vec_t tv[10];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Scoreboard: every handshake transfer must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (mon_en && wb_valid_o && wb_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got rd=%0d result=0x%08h, expected no output", wb_rd_o, wb_result_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_result", {32'h0, wb_result_o}, {32'h0, e.res});
        chk("wb_rd", {59'h0, wb_rd_o}, {59'h0, e.rd});
      end
    end
  end

  // Call at posedge+1. Holds the vector until it is accepted, then returns at
  // posedge+1 just after the accepting edge.
  task automatic send(input vec_t v, input bit track);
    int  t = 0;
    bit  ok = 1'b0;
    mul_valid_i = 1'b1; mul_res_w = v.prod; mul_op_i = v.op; mul_rd_i = v.rd;
    id_a_signed_r = v.as; id_b_signed_r = v.bs; id_ra_sign_r = v.ras; id_rb_sign_r = v.rbs;
    while (!ok && t < 50) begin
      @(negedge clk_i);
      if (mul_ready_o) begin
        ok = 1'b1;
        if (track) exp_q.push_back('{rd: v.rd, res: v.res});
      end
      @(posedge clk_i); #1;
      t++;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    mul_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin @(posedge clk_i); #1; t++; end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int lat;
    // Each row: product, a_signed, b_signed, a_sign, b_sign, op, rd, expected result.
    tv[0] = '{64'd21,                  1,1,1,0, 2'b00, 5'd1,  32'hFFFFFFEB}; // -3*7 MUL
    tv[1] = '{64'h4000000000000000,    1,1,1,1, 2'b01, 5'd2,  32'h40000000}; // MULH min*min
    tv[2] = '{64'hFFFFFFFE00000001,    0,0,1,1, 2'b11, 5'd3,  32'hFFFFFFFE}; // MULHU max*max
    tv[3] = '{64'h00000000FFFFFFFF,    1,0,1,1, 2'b10, 5'd4,  32'hFFFFFFFF}; // MULHSU -1*0xFFFFFFFF
    tv[4] = '{64'd0,                   1,0,1,0, 2'b01, 5'd5,  32'h00000000}; // negate zero, high
    tv[5] = '{64'd0,                   1,1,0,1, 2'b00, 5'd6,  32'h00000000}; // negate zero, low
    tv[6] = '{64'h123456789ABCDEF0,    0,0,0,0, 2'b00, 5'd7,  32'h9ABCDEF0}; // plain low half
    tv[7] = '{64'd6,                   1,1,1,0, 2'b01, 5'd8,  32'hFFFFFFFF}; // MULH -2*3
    tv[8] = '{64'h0000000500000003,    0,0,1,1, 2'b11, 5'd9,  32'h00000005}; // MULHU ignores sign bits
    tv[9] = '{64'h0000000080000000,    1,1,1,0, 2'b01, 5'd31, 32'hFFFFFFFF}; // MULH min*1

    // Reset state.
    #3;
    chk("rst_wb_valid", {63'h0, wb_valid_o}, 64'd0);
    chk("rst_wb_result", {32'h0, wb_result_o}, 64'd0);
    chk("rst_wb_rd", {59'h0, wb_rd_o}, 64'd0);
    chk("rst_busy", {63'h0, busy_o}, 64'd0);
    chk("rst_mul_ready", {63'h0, mul_ready_o}, 64'd1);
    #4 rst_i = 1'b0;
    @(posedge clk_i); #1;
    mon_en = 1'b1;

    // Table: one op at a time. Check the latency, then let the scoreboard check the data.
    for (int i = 0; i < 10; i++) begin
      send(tv[i], 1'b1);
      lat = 1;
      while (!wb_valid_o && lat < 10) begin @(posedge clk_i); #1; lat++; end
      chk($sformatf("latency_v%0d", i), 64'(lat), 64'(LAT));
      drain($sformatf("drain_v%0d", i));
      @(posedge clk_i); #1;
    end

    // Stream of 4 ops with write-back stalled for 3 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 4; i++) send(tv[i], 1'b1);
      end
      begin
        logic [31:0] held_res;
        logic [4:0]  held_rd;
        bit          have = 1'b0;
        bit          saw_full = 1'b0;
        @(posedge clk_i); #1;
        wb_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk_i);
          if (!mul_ready_o) saw_full = 1'b1;
          if (wb_valid_o) begin
            if (!have) begin held_res = wb_result_o; held_rd = wb_rd_o; have = 1'b1; end
            else begin
              chk("stall_result_stable", {32'h0, wb_result_o}, {32'h0, held_res});
              chk("stall_rd_stable", {59'h0, wb_rd_o}, {59'h0, held_rd});
            end
          end
          @(posedge clk_i); #1;
        end
        chk("stall_ready_dropped", {63'h0, saw_full}, 64'd1);
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        chk("ready_same_cycle", {63'h0, mul_ready_o}, 64'd1);
      end
    join
    drain("stream_drain");
    repeat (3) begin @(posedge clk_i); #1; end

    // Flush with every stage full plus a concurrent valid.
    wb_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(tv[4 + i], 1'b1);
    chk("flush_prefull_busy", {63'h0, busy_o}, 64'd1);
    mul_valid_i = 1'b1; mul_rd_i = 5'd20; mul_res_w = 64'd99; mul_op_i = 2'b00;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; mul_valid_i = 1'b0;
    exp_q.delete();
    chk("flush_wb_valid", {63'h0, wb_valid_o}, 64'd0);
    chk("flush_busy", {63'h0, busy_o}, 64'd0);
    wb_ready_i = 1'b1;
    repeat (6) begin @(posedge clk_i); #1; end

    // Flush with an accept into an empty pipe: the accept is dropped.
    mul_valid_i = 1'b1; mul_rd_i = 5'd21; flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; mul_valid_i = 1'b0;
    chk("flush_accept_dropped", {63'h0, busy_o}, 64'd0);
    repeat (4) begin @(posedge clk_i); #1; end

    // Asynchronous reset between edges while busy.
    wb_ready_i = 1'b0;
    send(tv[1], 1'b1);
    mon_en = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_wb_valid", {63'h0, wb_valid_o}, 64'd0);
    chk("arst_busy", {63'h0, busy_o}, 64'd0);
    chk("arst_mul_ready", {63'h0, mul_ready_o}, 64'd1);
    chk("arst_wb_result", {32'h0, wb_result_o}, 64'd0);
    chk("arst_wb_rd", {59'h0, wb_rd_o}, 64'd0);
    #1 rst_i = 1'b0;
    exp_q.delete();
    wb_ready_i = 1'b1;
    mon_en = 1'b1;
    repeat (5) begin @(posedge clk_i); #1; end
    chk("post_rst_busy", {63'h0, busy_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
